// File: rtl/register_module.sv
// register_module: 32 x 32-bit general-purpose register file, two operand read ports plus a debug read port.
// Latency: reads are combinational (zero cycles); a write becomes visible immediately after the rising edge.
// Backpressure: none; one write per cycle is always accepted, and every read port is always valid.
//
// Ports:
//   clk        - system clock, writes on rising edge
//   rst        - asynchronous active-high reset, clears every register
//   reg1_index - read port 1 address (rs); write target for code 2'b10
//   reg2_index - read port 2 address (rt); write target for code 2'b11
//   reg_write  - 00 none, 01 link register, 10 reg1_index, 11 reg2_index
//   data_write - write data
//   show_index - debug read address
//   reg1_value / reg2_value / reg_return - contents at reg1_index / reg2_index / show_index
module register_module #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int LINK_REG   = 31,
  parameter int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      reg1_index,
  input  logic [IDX_W-1:0]      reg2_index,
  input  logic [1:0]            reg_write,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic [IDX_W-1:0]      show_index,
  output logic [DATA_WIDTH-1:0] reg1_value,
  output logic [DATA_WIDTH-1:0] reg2_value,
  output logic [DATA_WIDTH-1:0] reg_return
);

  localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(LINK_REG);

  // Storage. Register 0 is an ordinary register (no hard-wired zero).
  logic [DATA_WIDTH-1:0] register_list [NUM_REGS];

  // Decoded write request for the coming edge.
  logic                  wr_en_d;
  logic [IDX_W-1:0]      wr_idx_d;

  // Only a non-zero code produces a write enable, so unknown data or index
  // values presented alongside code 00 cannot reach the array.
  always_comb begin
    wr_en_d  = 1'b0;
    wr_idx_d = '0;
    case (reg_write)
      2'b01: begin
        wr_en_d  = 1'b1;
        wr_idx_d = LINK_IDX;
      end
      2'b10: begin
        wr_en_d  = 1'b1;
        wr_idx_d = reg1_index;
      end
      2'b11: begin
        wr_en_d  = 1'b1;
        wr_idx_d = reg2_index;
      end
      default: begin
        wr_en_d  = 1'b0;
        wr_idx_d = '0;
      end
    endcase
  end

  // Reset wins over a same-edge write; asserting it between edges clears the
  // array at once and drops whatever write was set up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        register_list[i] <= '0;
      end
    end else if (wr_en_d && (int'(wr_idx_d) < NUM_REGS)) begin
      register_list[wr_idx_d] <= data_write;
    end
  end

  // Plain array reads with no bypass: a same-cycle write shows up only after
  // the edge that commits it.
  always_comb begin
    reg1_value = register_list[reg1_index];
    reg2_value = register_list[reg2_index];
    reg_return = register_list[show_index];
  end

endmodule

// File: tb/tb_register_module.sv
module tb_register_module;

  logic        clk;
  logic        rst;
  logic [4:0]  reg1_index;
  logic [4:0]  reg2_index;
  logic [1:0]  reg_write;
  logic [31:0] data_write;
  logic [4:0]  show_index;
  logic [31:0] reg1_value;
  logic [31:0] reg2_value;
  logic [31:0] reg_return;

  int checks = 0;
  int errors = 0;

  register_module dut (
    .clk        (clk),
    .rst        (rst),
    .reg1_index (reg1_index),
    .reg2_index (reg2_index),
    .reg_write  (reg_write),
    .data_write (data_write),
    .show_index (show_index),
    .reg1_value (reg1_value),
    .reg2_value (reg2_value),
    .reg_return (reg_return)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wr;
    logic [4:0]  i1;
    logic [4:0]  i2;
    logic [4:0]  sh;
    logic [31:0] dat;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] er;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] er;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_ports(input string name, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] er);
    check32({name, ".reg1_value"}, reg1_value, e1);
    check32({name, ".reg2_value"}, reg2_value, e2);
    check32({name, ".reg_return"}, reg_return, er);
  endtask

  // Drive one vector at a falling edge, queue its expectation, commit on the
  // rising edge, then pop and compare just after it.
  task automatic apply_vec(input int id, input vec_t v);
    exp_t e;
    reg_write  = v.wr;
    reg1_index = v.i1;
    reg2_index = v.i2;
    show_index = v.sh;
    data_write = v.dat;
    sb.push_back('{id, v.e1, v.e2, v.er});
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: empty at vec %0d, expected 1 entry", id);
    end else begin
      checks--;
      e = sb.pop_front();
      check_ports($sformatf("vec%0d", e.id), e.e1, e.e2, e.er);
    end
    @(negedge clk);
  endtask

  logic [31:0] final_exp [32];

  initial begin
    // {wr, rs, rt, show, data, exp reg1_value, exp reg2_value, exp reg_return}
    vecs[0] = '{2'b10, 5'd1,  5'd2,  5'd1,  32'd16,         32'd16,         32'd0,          32'd16};
    vecs[1] = '{2'b11, 5'd1,  5'd2,  5'd1,  32'd22,         32'd16,         32'd22,         32'd16};
    vecs[2] = '{2'b00, 5'd1,  5'd2,  5'd2,  32'hDEAD_BEEF,  32'd16,         32'd22,         32'd22};
    vecs[3] = '{2'b00, 5'd1,  5'd2,  5'd2,  32'hFFFF_FFFF,  32'd16,         32'd22,         32'd22};
    vecs[4] = '{2'b10, 5'd1,  5'd2,  5'd2,  32'd20,         32'd20,         32'd22,         32'd22};
    vecs[5] = '{2'b01, 5'd2,  5'd1,  5'd31, 32'd9,          32'd22,         32'd20,         32'd9};
    vecs[6] = '{2'b10, 5'd0,  5'd31, 5'd0,  32'hA5A5_0001,  32'hA5A5_0001,  32'd9,          32'hA5A5_0001};
    vecs[7] = '{2'b11, 5'd0,  5'd31, 5'd31, 32'h8000_0000,  32'hA5A5_0001,  32'h8000_0000,  32'h8000_0000};
    vecs[8] = '{2'b00, 5'd31, 5'd31, 5'd31, 32'h1234_5678,  32'h8000_0000,  32'h8000_0000,  32'h8000_0000};
    vecs[9] = '{2'b10, 5'd5,  5'd5,  5'd5,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};

    for (int i = 0; i < 32; i++) final_exp[i] = 32'd0;
    final_exp[0]  = 32'hA5A5_0001;
    final_exp[1]  = 32'd20;
    final_exp[2]  = 32'd22;
    final_exp[5]  = 32'hFFFF_FFFF;
    final_exp[31] = 32'h8000_0000;

    rst        = 1'b1;
    reg1_index = 5'd1;
    reg2_index = 5'd2;
    show_index = 5'd31;
    reg_write  = 2'b10;
    data_write = 32'h5555_5555;

    // Reset held over several edges with a write requested: nothing lands.
    #50;
    check_ports("reset", 32'd0, 32'd0, 32'd0);
    #50;
    rst = 1'b0;

    // Table-driven sequence (starts at a falling edge, t=100).
    for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

    // Debug port follows show_index with no clock.
    reg_write  = 2'b00;
    show_index = 5'd2;
    #1 check32("show_comb_r2", reg_return, 32'd22);
    show_index = 5'd0;
    #1 check32("show_comb_r0", reg_return, 32'hA5A5_0001);

    // No bypass: before the edge reg1_value still shows the old contents.
    reg1_index = 5'd1;
    reg_write  = 2'b10;
    data_write = 32'd777;
    #1 check32("rdw_before_edge", reg1_value, 32'd20);
    reg_write  = 2'b00;
    data_write = 32'd0;

    // Unknown data/indices while the code is 00 must not change state.
    @(negedge clk);
    data_write = 'x;
    reg1_index = 'x;
    reg2_index = 'x;
    @(posedge clk);
    @(negedge clk);
    reg1_index = 5'd1;
    reg2_index = 5'd2;
    data_write = 32'd0;
    #1;
    for (int i = 0; i < 32; i++)
      check32($sformatf("array[%0d]", i), dut.register_list[i], final_exp[i]);

    // Asynchronous reset between edges clears everything immediately.
    reg_write  = 2'b11;
    data_write = 32'hCAFE_F00D;
    show_index = 5'd31;
    #1 rst = 1'b1;
    #1;
    check_ports("async_rst", 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 32; i += 5)
      check32($sformatf("rst_array[%0d]", i), dut.register_list[i], 32'd0);
    @(posedge clk);
    #1 check32("rst_priority_r2", reg2_value, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    reg_write = 2'b00;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
